// File: rtl/alu_pkg.sv
// Shared definitions for the alu and its issue stage: op encoding, default widths, slot states.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011
  } alu_op_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command and result handshakes of the alu issue stage.
interface alu_issue_stage_if #(
  parameter int WIDTH = alu_pkg::WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic [2:0]       out_op;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_op
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_op
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO holding {a, b, op}; head is presented combinationally and reads as zero when empty.
module alu_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_a,
  input  logic [WIDTH-1:0] push_b,
  input  logic [2:0]       push_op,
  input  logic             pop,
  output logic [WIDTH-1:0] head_a,
  output logic [WIDTH-1:0] head_b,
  output logic [2:0]       head_op,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_a  [DEPTH];
  logic [WIDTH-1:0] mem_b  [DEPTH];
  logic [2:0]       mem_op [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_a  = empty ? '0 : mem_a[rd_ptr];
  assign head_b  = empty ? '0 : mem_b[rd_ptr];
  assign head_op = empty ? '0 : mem_op[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_a[wr_ptr]  <= push_a;
      mem_b[wr_ptr]  <= push_b;
      mem_op[wr_ptr] <= push_op;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: buffers alu commands, feeds the FIFO head to the alu and registers its result.
//   state      | meaning
//   SLOT_EMPTY | no result waiting for the consumer
//   SLOT_FULL  | out_result/out_zero/out_op valid, held until out_ready
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int DEPTH = alu_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_stage_if.slave   cmd,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero,
  output logic [15:0]        issue_cnt
);

  slot_state_e      state;
  slot_state_e      state_nxt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             issue;
  logic [WIDTH-1:0] slot_result;
  logic             slot_zero;
  logic [2:0]       slot_op;

  assign cmd.in_ready = !fifo_full;
  assign push         = cmd.in_valid && !fifo_full;

  alu_cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_a  (cmd.in_a),
    .push_b  (cmd.in_b),
    .push_op (cmd.in_op),
    .pop     (issue),
    .head_a  (alu_a),
    .head_b  (alu_b),
    .head_op (alu_op),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SLOT_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = !fifo_empty && ((state == SLOT_EMPTY) || cmd.out_ready);
    if (issue)
      state_nxt = SLOT_FULL;
    else if ((state == SLOT_FULL) && cmd.out_ready)
      state_nxt = SLOT_EMPTY;
  end

  // A new issue overwrites the slot only when it is empty or being consumed this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_result <= '0;
      slot_zero   <= 1'b0;
      slot_op     <= '0;
      issue_cnt   <= '0;
    end else if (issue) begin
      slot_result <= alu_result;
      slot_zero   <= alu_zero;
      slot_op     <= alu_op;
      issue_cnt   <= issue_cnt + 16'd1;
    end
  end

  assign cmd.out_valid  = (state == SLOT_FULL);
  assign cmd.out_result = slot_result;
  assign cmd.out_zero   = slot_zero;
  assign cmd.out_op     = slot_op;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural alu wired to the alu_* ports.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [15:0] issue_cnt;
  int          n_cmp;
  int          n_err;

  alu_issue_stage_if #(.WIDTH(32)) bus ();

  alu_issue_stage #(.WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .issue_cnt  (issue_cnt)
  );

  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed=timeout expected=finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 3'd0);

    // Reset state
    #3;
    chk("rst_in_ready",   32'(bus.in_ready),  32'd1);
    chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_out_result", bus.out_result,     32'd0);
    chk("rst_out_zero",   32'(bus.out_zero),  32'd0);
    chk("rst_out_op",     32'(bus.out_op),    32'd0);
    chk("rst_issue_cnt",  32'(issue_cnt),     32'd0);
    chk("rst_alu_a",      alu_a,              32'd0);
    chk("rst_alu_op",     32'(alu_op),        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1. single op, latency
    drive(1'b1, 32'd10, 32'd5, ADD);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    chk("t1_valid_early", 32'(bus.out_valid), 32'd0);
    chk("t1_alu_a_head",  alu_a,              32'd10);
    chk("t1_alu_b_head",  alu_b,              32'd5);
    tick();
    chk("t1_out_valid",  32'(bus.out_valid), 32'd1);
    chk("t1_out_result", bus.out_result,     32'd15);
    chk("t1_out_zero",   32'(bus.out_zero),  32'd0);
    chk("t1_out_op",     32'(bus.out_op),    32'd0);
    chk("t1_issue_cnt",  32'(issue_cnt),     32'd1);
    tick();
    chk("t1_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("t1_alu_a_idle", alu_a,              32'd0);

    // 2. zero flag
    drive(1'b1, 32'd100, 32'd100, SUB);
    tick();
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    tick();
    chk("t2_out_result", bus.out_result,    32'd0);
    chk("t2_out_zero",   32'(bus.out_zero), 32'd1);
    chk("t2_out_op",     32'(bus.out_op),   32'd1);
    chk("t2_issue_cnt",  32'(issue_cnt),    32'd2);
    tick();

    // 3. backpressure, then ordered drain
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0000_F0F0, 32'h0000_0FF0, AND); tick();
    drive(1'b1, 32'h0000_F000, 32'h0000_0F00, OR);  tick();
    drive(1'b1, 32'd7, 32'd3, SUB);                 tick();
    drive(1'b1, 32'd1, 32'd2, ADD);                 tick();
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, ADD);         tick();
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    chk("t3_in_ready_full", 32'(bus.in_ready),  32'd0);
    chk("t3_out_valid",     32'(bus.out_valid), 32'd1);
    chk("t3_slot_first",    bus.out_result,     32'h0000_00F0);
    chk("t3_fifo_head",     alu_a,              32'h0000_F000);
    tick();
    tick();
    chk("t3_slot_held",   bus.out_result,    32'h0000_00F0);
    chk("t3_op_held",     32'(bus.out_op),   32'd2);
    chk("t3_cnt_held",    32'(issue_cnt),    32'd3);
    bus.out_ready = 1'b1;
    tick();
    chk("t3_drain1",       bus.out_result,    32'h0000_FF00);
    chk("t3_in_ready_ret", 32'(bus.in_ready), 32'd1);
    tick();
    chk("t3_drain2", bus.out_result, 32'd4);
    tick();
    chk("t3_drain3", bus.out_result, 32'd3);
    tick();
    chk("t3_drain4",      bus.out_result,    32'd0);
    chk("t3_drain4_zero", 32'(bus.out_zero), 32'd1);
    chk("t3_issue_cnt",   32'(issue_cnt),    32'd7);
    tick();
    chk("t3_empty", 32'(bus.out_valid), 32'd0);

    // 4. streaming after a fresh reset
    pulse_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), 32'd1, ADD);
      chk("t4_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      if (i == 0) begin
        chk("t4_first_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        chk("t4_valid",  32'(bus.out_valid), 32'd1);
        chk("t4_result", bus.out_result,     32'(i));
      end
    end
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    tick();
    chk("t4_last_result", bus.out_result, 32'd8);
    chk("t4_issue_cnt",   32'(issue_cnt), 32'd8);
    tick();
    chk("t4_drained", 32'(bus.out_valid), 32'd0);

    // 5. reset mid-operation
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i + 20), 32'd0, OR);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    chk("t5_pre_valid",    32'(bus.out_valid), 32'd1);
    chk("t5_pre_in_ready", 32'(bus.in_ready),  32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid",    32'(bus.out_valid), 32'd0);
    chk("t5_rst_in_ready", 32'(bus.in_ready),  32'd1);
    chk("t5_rst_cnt",      32'(issue_cnt),     32'd0);
    chk("t5_rst_alu_a",    alu_a,              32'd0);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("t5_no_stale", 32'(bus.out_valid), 32'd0);
    chk("t5_cnt_post", 32'(issue_cnt),     32'd0);

    // 6. full FIFO refuses a push even while popping
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'(i), 32'd0, ADD);
      tick();
    end
    chk("t6_full",      32'(bus.in_ready), 32'd0);
    chk("t6_slot",      bus.out_result,    32'd1);
    chk("t6_head",      alu_a,             32'd2);
    drive(1'b1, 32'd6, 32'd0, ADD);
    bus.out_ready = 1'b1;
    tick();
    chk("t6_pop_result", bus.out_result,    32'd2);
    chk("t6_refused",    32'(bus.in_ready), 32'd1);
    chk("t6_head_after", alu_a,             32'd3);
    bus.out_ready = 1'b0;
    tick();
    drive(1'b0, 32'd0, 32'd0, 3'd0);
    chk("t6_accepted",   32'(bus.in_ready), 32'd0);
    chk("t6_slot_held",  bus.out_result,    32'd2);
    bus.out_ready = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      tick();
      chk("t6_drain", bus.out_result, 32'(i));
    end
    tick();
    chk("t6_empty",     32'(bus.out_valid), 32'd0);
    chk("t6_issue_cnt", 32'(issue_cnt),     32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
